// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter granting exclusive write ownership of one shared
// register to one of four requesters, with a hold counter to bound tenure.
module rr_reg_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3:0]         req,
    input  logic [3:0]         wr,
    input  logic [4*WIDTH-1:0] wdata,
    output logic [3:0]         grant,
    output logic [1:0]         owner,
    output logic               busy,
    output logic [WIDTH-1:0]   q
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWN   = 1'b1;
    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    logic [0:0]       r_state;
    logic [3:0]       r_grant;
    logic [1:0]       r_owner;
    logic [1:0]       r_ptr;
    logic [3:0]       r_hold;
    logic [WIDTH-1:0] r_q;

    logic [3:0]       w_owner_oh;
    logic [3:0]       w_others;
    logic             w_any_other;
    logic             w_hold_max;
    logic             w_release;
    logic [1:0]       w_next_ptr;
    logic [1:0]       w_idle_pick;
    logic [1:0]       w_rot_pick;
    logic             w_write;
    logic [WIDTH-1:0] w_wr_slice;

    // First set bit of mask, scanning start, start+1, ... modulo 4.
    function automatic logic [1:0] f_pick(
        input logic [3:0] mask,
        input logic [1:0] start
    );
        logic [1:0] idx;
        f_pick = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (mask[idx]) begin
                f_pick = idx;
            end
        end
    endfunction

    assign w_owner_oh  = 4'b0001 << r_owner;
    assign w_others    = req & ~w_owner_oh;
    assign w_any_other = |w_others;
    assign w_hold_max  = (r_hold == HOLD_MAX);
    assign w_release   = !req[r_owner] || (w_hold_max && w_any_other);
    assign w_next_ptr  = r_owner + 2'd1;
    assign w_idle_pick = f_pick(req, r_ptr);
    // Old owner is excluded from the search, so it is served last.
    assign w_rot_pick  = f_pick(w_others, w_next_ptr);
    assign w_write     = (r_state == ST_OWN) && wr[r_owner];
    assign w_wr_slice  = wdata[r_owner*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_grant <= 4'b0000;
            r_owner <= 2'd0;
            r_ptr   <= 2'd0;
            r_hold  <= 4'd0;
            r_q     <= '0;
        end else begin
            if (w_write) begin
                r_q <= w_wr_slice;
            end
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_state <= ST_OWN;
                        r_owner <= w_idle_pick;
                        r_grant <= 4'b0001 << w_idle_pick;
                        r_hold  <= 4'd1;
                    end
                end
                ST_OWN: begin
                    if (w_release) begin
                        r_ptr <= w_next_ptr;
                        if (w_any_other) begin
                            r_owner <= w_rot_pick;
                            r_grant <= 4'b0001 << w_rot_pick;
                            r_hold  <= 4'd1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_owner <= 2'd0;
                            r_grant <= 4'b0000;
                            r_hold  <= 4'd0;
                        end
                    end else if (!w_hold_max) begin
                        r_hold <= r_hold + 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign owner = r_owner;
    assign busy  = (r_state == ST_OWN);
    assign q     = r_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Scoreboard bench for rr_reg_arbiter: directed scenarios then random
// traffic, all checked against a behavioural round-robin model.
module tb_rr_reg_arbiter;

    localparam int W  = 8;
    localparam int MH = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   req = '0;
    logic [3:0]   wr = '0;
    logic [4*W-1:0] wdata = '0;
    logic [3:0]   grant;
    logic [1:0]   owner;
    logic         busy;
    logic [W-1:0] q;

    rr_reg_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .wr(wr), .wdata(wdata),
        .grant(grant), .owner(owner), .busy(busy), .q(q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   g;
        logic [1:0]   o;
        logic         b;
        logic [W-1:0] q;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // model state: m_own = -1 means nobody owns the register
    int m_own = -1;
    int m_ptr = 0;
    int m_hold = 0;
    logic [W-1:0] m_q = '0;

    function automatic int first_from(input logic [3:0] mask, input int start);
        for (int k = 0; k < 4; k++) begin
            if (mask[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    function automatic void model_step(input logic rst, input logic [3:0] rq,
                                       input logic [3:0] w, input logic [4*W-1:0] d);
        logic [3:0] others;
        if (!rst) begin
            m_own = -1; m_ptr = 0; m_hold = 0; m_q = '0;
        end else if (m_own < 0) begin
            if (rq != 0) begin
                m_own = first_from(rq, m_ptr);
                m_hold = 1;
            end
        end else begin
            if (w[m_own]) m_q = d[m_own*W +: W];
            others = rq;
            others[m_own] = 1'b0;
            if (!rq[m_own] || (m_hold == MH && others != 0)) begin
                m_ptr = (m_own + 1) % 4;
                if (others != 0) begin
                    m_own = first_from(others, m_ptr);
                    m_hold = 1;
                end else begin
                    m_own = -1;
                    m_hold = 0;
                end
            end else if (m_hold < MH) begin
                m_hold++;
            end
        end
    endfunction

    task automatic step(input logic rst, input logic [3:0] rq,
                        input logic [3:0] w, input logic [4*W-1:0] d);
        exp_t e;
        @(negedge clk);
        reset_n = rst; req = rq; wr = w; wdata = d;
        model_step(rst, rq, w, d);
        e.g = (m_own < 0) ? 4'b0000 : 4'(1 << m_own);
        e.o = (m_own < 0) ? 2'd0 : 2'(m_own);
        e.b = (m_own >= 0);
        e.q = m_q;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Check constants just after the edge that consumed the last step.
    task automatic post(input string name, input logic [3:0] g, input logic [7:0] qq);
        @(posedge clk);
        #2;
        chk({name, ".grant"}, {4'b0, grant}, {4'b0, g});
        chk({name, ".q"}, q, qq);
    endtask

    function automatic logic [4*W-1:0] slice(input int i, input logic [W-1:0] v);
        logic [4*W-1:0] r;
        r = '0;
        r[i*W +: W] = v;
        return r;
    endfunction

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("mon.grant", {4'b0, grant}, {4'b0, e.g});
                chk("mon.owner", {6'b0, owner}, {6'b0, e.o});
                chk("mon.busy", {7'b0, busy}, {7'b0, e.b});
                chk("mon.q", q, e.q);
                chk("mon.onehot", {7'b0, $onehot0(grant)}, 8'd1);
            end
        end
    end

    initial begin
        logic [3:0] rq;
        // reset with everything asserted
        step(0, 4'b1111, 4'b1111, '1);
        step(0, 4'b1111, 4'b1111, '1);
        post("rst", 4'b0000, 8'h00);
        chk("rst.busy", {7'b0, busy}, 8'd0);
        chk("rst.owner", {6'b0, owner}, 8'd0);
        step(1, 4'b1111, 4'b0000, '0);
        post("rst_rel", 4'b0001, 8'h00);
        step(1, 4'b0000, 4'b0000, '0);

        // single requester
        step(1, 4'b0100, 4'b0000, '0);
        post("single.g", 4'b0100, 8'h00);
        chk("single.owner", {6'b0, owner}, 8'd2);
        step(1, 4'b0100, 4'b0100, slice(2, 8'hA5));
        post("single.w", 4'b0100, 8'hA5);
        step(1, 4'b0000, 4'b0000, '0);
        post("single.drop", 4'b0000, 8'hA5);
        chk("single.busy", {7'b0, busy}, 8'd0);

        // simultaneous requests from ptr=0, back-to-back handover
        step(0, 4'b0000, 4'b0000, '0);
        step(1, 4'b1010, 4'b0000, '0);
        post("simul.1", 4'b0010, 8'h00);
        step(1, 4'b1000, 4'b0010, slice(1, 8'h11));
        post("simul.2", 4'b1000, 8'h11);
        step(1, 4'b1000, 4'b1000, slice(3, 8'h22));
        post("simul.3", 4'b1000, 8'h22);
        step(1, 4'b0000, 4'b0000, '0);

        // forced rotation after MAX_HOLD cycles
        step(0, 4'b0000, 4'b0000, '0);
        step(1, 4'b0001, 4'b0000, '0);
        post("rot.0", 4'b0001, 8'h00);
        for (int i = 1; i < MH; i++) begin
            step(1, 4'b1001, 4'b0000, '0);
            post("rot.hold", 4'b0001, 8'h00);
        end
        step(1, 4'b1001, 4'b0000, '0);
        post("rot.sw", 4'b1000, 8'h00);
        step(1, 4'b0001, 4'b0000, '0);
        post("rot.back", 4'b0001, 8'h00);
        step(1, 4'b0000, 4'b0000, '0);

        // non-owner write ignored
        step(0, 4'b0000, 4'b0000, '0);
        step(1, 4'b0010, 4'b0000, '0);
        step(1, 4'b0010, 4'b0001, slice(0, 8'hFF));
        post("nonown", 4'b0010, 8'h00);
        step(1, 4'b0010, 4'b0010, slice(1, 8'h3C));
        post("own.w", 4'b0010, 8'h3C);

        // reset mid-ownership discards write, ptr returns to 0
        step(1, 4'b0100, 4'b0000, '0);
        step(1, 4'b0100, 4'b0000, '0);
        step(0, 4'b0100, 4'b0100, slice(2, 8'h77));
        post("midrst", 4'b0000, 8'h00);
        step(1, 4'b1111, 4'b0000, '0);
        post("midrst.ptr", 4'b0001, 8'h00);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rq = 4'($urandom) & 4'($urandom | $urandom);
            step(($urandom_range(0, 99) != 0), rq, 4'($urandom),
                 {$urandom});
        end
        step(1, 4'b0000, 4'b0000, '0);

        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, 0 required", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
